// File: rtl/rr_arb_1hot.sv
// Round-robin arbiter producing a registered one-hot grant that directly drives
// a one-hot mux select; a grant is held until the consumer acknowledges it.
module rr_arb_1hot #(
  parameter  int N    = 8,
  localparam int IDXW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic            ack,
  output logic [N-1:0]    gnt,
  output logic            gnt_vld,
  output logic [IDXW-1:0] gnt_idx
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [IDXW-1:0] ptr_q, ptr_d;

  logic [IDXW-1:0] cand;
  logic [IDXW-1:0] win_idx;
  logic            win_found;

  // Circular search starting just past the last winner, so it ranks lowest.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IDXW'((int'(ptr_q) + k) % N);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    // Arbitrate only when nothing is held or the held grant is being released.
    if ((state_q == ST_IDLE) || ack) begin
      if (win_found) begin
        state_d = ST_GRANT;
        gnt_d   = N'(1) << win_idx;
        idx_d   = win_idx;
        ptr_d   = win_idx;
      end else begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        idx_d   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      ptr_q   <= IDXW'(N - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_idx = idx_q;
  assign gnt_vld = (state_q == ST_GRANT);

endmodule

// File: tb/tb_rr_arb_1hot.sv
// Directed and randomized checks of rr_arb_1hot at N=4 against hand-computed
// grant sequences and a small round-robin reference model.
module tb_rr_arb_1hot;

  localparam int N = 4;

  logic         clk;
  logic         rst;
  logic [N-1:0] req;
  logic         ack;
  logic [N-1:0] gnt;
  logic         gnt_vld;
  logic [1:0]   gnt_idx;

  int checks = 0;
  int errors = 0;

  rr_arb_1hot #(.N(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .ack     (ack),
    .gnt     (gnt),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Inputs seen at each rising edge, used by the stability invariant.
  logic last_ack = 1'b0;
  logic last_rst = 1'b1;
  always @(posedge clk) begin
    last_ack <= ack;
    last_rst <= rst;
  end

  // Every-cycle invariants on the grant outputs, sampled mid-cycle.
  logic [N-1:0] prev_gnt  = '0;
  logic         prev_vld  = 1'b0;
  logic         have_prev = 1'b0;
  always @(negedge clk) begin
    logic [1:0] bit_idx;
    bit_idx = 2'd0;
    for (int i = 0; i < N; i++) if (gnt[i]) bit_idx = 2'(i);
    checks++;
    assert ($onehot0(gnt)) else begin
      errors++;
      $error("[TB] FAIL inv_onehot0: observed gnt=%b required onehot0", gnt);
    end
    checks++;
    assert (gnt_vld === |gnt) else begin
      errors++;
      $error("[TB] FAIL inv_vld: observed gnt_vld=%b required %b", gnt_vld, |gnt);
    end
    checks++;
    assert (gnt_idx === bit_idx) else begin
      errors++;
      $error("[TB] FAIL inv_idx: observed gnt_idx=%0d required %0d", gnt_idx, bit_idx);
    end
    if (have_prev && prev_vld && !last_ack && !last_rst) begin
      checks++;
      assert (gnt === prev_gnt) else begin
        errors++;
        $error("[TB] FAIL inv_hold: observed gnt=%b required %b", gnt, prev_gnt);
      end
    end
    prev_gnt  = gnt;
    prev_vld  = gnt_vld;
    have_prev = 1'b1;
  end

  task automatic apply_stimulus(input logic [N-1:0] r, input logic a, input logic x);
    req = r;
    ack = a;
    rst = x;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_output(input string tag, input logic [N-1:0] exp_gnt);
    logic [1:0] exp_idx;
    exp_idx = 2'd0;
    for (int i = 0; i < N; i++) if (exp_gnt[i]) exp_idx = 2'(i);
    checks++;
    assert (gnt === exp_gnt) else begin
      errors++;
      $error("[TB] FAIL %s gnt: observed %b required %b", tag, gnt, exp_gnt);
    end
    checks++;
    assert (gnt_vld === |exp_gnt) else begin
      errors++;
      $error("[TB] FAIL %s gnt_vld: observed %b required %b", tag, gnt_vld, |exp_gnt);
    end
    checks++;
    assert (gnt_idx === exp_idx) else begin
      errors++;
      $error("[TB] FAIL %s gnt_idx: observed %0d required %0d", tag, gnt_idx, exp_idx);
    end
  endtask

  function automatic logic [1:0] rr_pick(input logic [N-1:0] r, input logic [1:0] p);
    logic [1:0] c;
    for (int k = 1; k <= N; k++) begin
      c = p + 2'(k);
      if (r[c]) return c;
    end
    return p;
  endfunction

  initial begin
    logic [N-1:0] m_gnt;
    logic [1:0]   m_ptr;
    logic [1:0]   w;
    logic [N-1:0] r;
    logic         a;
    int           waits[N];

    rst = 1'b1;
    req = '0;
    ack = 1'b0;
    @(negedge clk);

    apply_stimulus(4'b0000, 1'b0, 1'b1); check_output("reset", 4'b0000);

    // All requesting with ack every cycle rotates 0,1,2,3,0.
    apply_stimulus(4'b1111, 1'b1, 1'b0); check_output("rot0", 4'b0001);
    apply_stimulus(4'b1111, 1'b1, 1'b0); check_output("rot1", 4'b0010);
    apply_stimulus(4'b1111, 1'b1, 1'b0); check_output("rot2", 4'b0100);
    apply_stimulus(4'b1111, 1'b1, 1'b0); check_output("rot3", 4'b1000);
    apply_stimulus(4'b1111, 1'b1, 1'b0); check_output("rot4", 4'b0001);

    // Grant held without ack even after req drops, released by ack.
    apply_stimulus(4'b0000, 1'b1, 1'b0); check_output("to_idle", 4'b0000);
    apply_stimulus(4'b0100, 1'b0, 1'b0); check_output("hold_grant", 4'b0100);
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(4'b0000, 1'b0, 1'b0); check_output("hold_keep", 4'b0100);
    end
    apply_stimulus(4'b0000, 1'b1, 1'b0); check_output("hold_release", 4'b0000);

    // Pointer at 2 searches 3,0,1; then re-arbitration skips past the holder.
    apply_stimulus(4'b0010, 1'b0, 1'b0); check_output("idx1_grant", 4'b0010);
    apply_stimulus(4'b1011, 1'b0, 1'b0); check_output("idx1_hold", 4'b0010);
    apply_stimulus(4'b1011, 1'b1, 1'b0); check_output("rearb_3", 4'b1000);
    apply_stimulus(4'b0011, 1'b1, 1'b0); check_output("rearb_0", 4'b0001);

    // Sole requester is re-granted back to back with no bubble.
    apply_stimulus(4'b0010, 1'b1, 1'b0); check_output("sole0", 4'b0010);
    apply_stimulus(4'b0010, 1'b1, 1'b0); check_output("sole1", 4'b0010);
    apply_stimulus(4'b0010, 1'b1, 1'b0); check_output("sole2", 4'b0010);

    // Reset overrides a held grant and restores requester 0 as first winner.
    apply_stimulus(4'b1000, 1'b1, 1'b0); check_output("pre_rst", 4'b1000);
    apply_stimulus(4'b0000, 1'b0, 1'b0); check_output("pre_rst_hold", 4'b1000);
    apply_stimulus(4'b1111, 1'b1, 1'b1); check_output("rst_held", 4'b0000);
    apply_stimulus(4'b1111, 1'b0, 1'b0); check_output("post_rst", 4'b0001);

    // Ack while idle changes nothing.
    apply_stimulus(4'b0000, 1'b1, 1'b0); check_output("idle0", 4'b0000);
    apply_stimulus(4'b0000, 1'b1, 1'b0); check_output("idle_ack", 4'b0000);

    // Random traffic against the reference model with a starvation bound.
    apply_stimulus(4'b0000, 1'b0, 1'b1); check_output("rand_reset", 4'b0000);
    m_gnt = '0;
    m_ptr = 2'd3;
    for (int i = 0; i < N; i++) waits[i] = 0;
    for (int c = 0; c < 10000; c++) begin
      r = 4'($urandom);
      a = ($urandom_range(0, 3) != 0);
      if (m_gnt == '0 || a) begin
        if (|r) begin
          w = rr_pick(r, m_ptr);
          for (int i = 0; i < N; i++) begin
            if (!r[i] || (2'(i) == w)) waits[i] = 0;
            else begin
              waits[i]++;
              checks++;
              assert (waits[i] <= N - 1) else begin
                errors++;
                $error("[TB] FAIL starve req%0d: observed %0d losses required <= %0d", i, waits[i], N - 1);
              end
            end
          end
          m_gnt = 4'b0001 << w;
          m_ptr = w;
        end else begin
          m_gnt = '0;
          for (int i = 0; i < N; i++) waits[i] = 0;
        end
      end
      apply_stimulus(r, a, 1'b0);
      checks++;
      assert (gnt === m_gnt) else begin
        errors++;
        $error("[TB] FAIL rand_gnt cycle %0d: observed %b required %b", c, gnt, m_gnt);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_arb_1hot.md
Name: rr_arb_1hot

Overview:
- Round-robin arbiter that turns N request lines into a registered one-hot grant.
- The grant drives the select input of the downstream one-hot mux directly.
- The grant is held stable until the downstream consumer acknowledges it.
- Guarantees the mux select is always one-hot or all-zero, so the mux never sees an illegal select.

Parameters:
- N, 8, number of requesters / mux inputs (N >= 1).
- IDXW, (N>1 ? clog2(N) : 1), width of the binary index output (derived; do not override).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- req  input  N  request vector; bit i = requester i wants the mux.
- ack  input  1  downstream accepted the current grant this cycle; meaningful only when gnt_vld=1.
- gnt  output N  registered one-hot grant; drives mux sel.
- gnt_vld  output 1  a grant is held; always equal to |gnt.
- gnt_idx  output IDXW  binary index of the set bit of gnt; 0 when gnt_vld=0.

Behaviour:
- Reset (sampled at clk edge with rst=1, overrides everything including a held grant):
  - gnt=0, gnt_vld=0, gnt_idx=0.
  - Priority pointer ptr=N-1, so requester 0 wins first after reset.
- States: IDLE (gnt_vld=0), GRANT (gnt_vld=1). No other state.
- Winner selection: first set bit of req searched circularly from (ptr+1) mod N upward. On a win, ptr <= winner index.
- IDLE:
  - |req=1: next cycle GRANT with gnt = one-hot(winner) and gnt_idx = winner. Latency req -> gnt is exactly 1 cycle.
  - req=0: stay IDLE.
- GRANT, ack=0:
  - gnt and gnt_idx are held unchanged, even if req changes or the granted requester drops its req.
  - No pre-emption.
- GRANT, ack=1:
  - |req=1: next cycle re-arbitrate using the current-cycle req and current ptr. Back-to-back grant, no bubble cycle.
  - The just-served requester has lowest priority. It is re-granted only if it is the sole requester.
  - req=0: next cycle IDLE, gnt=0.
- ack while IDLE is ignored; no state change.
- rst and ack in the same cycle: rst wins.
- N=1: ptr stays 0; behaves as a request/hold/ack latch on req[0].
- Invariants (to be checked by bench assertions every cycle):
  - gnt is onehot0.
  - gnt_vld == |gnt.
  - gnt_idx == index of the set bit of gnt.
  - gnt is stable while gnt_vld && !ack.
- Fairness: with all N requesting continuously and ack=1 every cycle, each requester is granted exactly once in every N consecutive grants.

Test Plan (N=4):
- Reset, then req=4'b1111 held, ack=1 every cycle -> gnt sequence 0001, 0010, 0100, 1000, 0001, ...; gnt_idx sequence 0, 1, 2, 3, 0.
- req=4'b0100 for 1 cycle, ack=0 for 5 cycles, then ack=1 -> gnt=0100 from cycle 1, held 5+ cycles even though req=0; next cycle gnt=0, gnt_vld=0.
- Grant held on idx 1, req changes to 4'b1011, ack=1 -> next gnt=1000 (idx 3, searched from 2); following ack with req=4'b0011 -> gnt=0001.
- Single requester req=4'b0010, ack=1 every cycle -> gnt=0010 continuously with no bubble.
- rst=1 asserted while gnt=1000 and ack=0 -> next cycle gnt=0, gnt_vld=0, gnt_idx=0; with req=1111 after reset, first grant is 0001.
- Random req/ack for 10k cycles -> all invariants hold; no requester with req continuously high waits more than 3 grants.
